// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer running entirely in the clk200 domain.
// A dot-enable strobe paces the horizontal/vertical counters, and all
// video outputs are registered from the post-advance counter values.
module vga_timing_ctrl #(
  parameter int unsigned DIV      = 8,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk200,
  input  logic       rst_n,
  input  logic       run,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_div,
  output logic       cfg_ready,
  output logic       dot_en,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t     state;
  logic [3:0] cur_div;
  logic [3:0] pend_div;
  logic [3:0] div_cnt;
  logic [3:0] cfg_clamped;
  logic [9:0] nx;
  logic [9:0] ny;
  logic       x_last;
  logic       y_last;
  logic       frame_end;
  logic       xfer;
  logic       apply;

  function automatic logic de_at(input logic [9:0] px, input logic [9:0] py);
    return (32'(px) < H_ACTIVE) && (32'(py) < V_ACTIVE);
  endfunction

  function automatic logic hs_at(input logic [9:0] px);
    return ((32'(px) >= HS_BEG) && (32'(px) < HS_END)) ? SYNC_POL : ~SYNC_POL;
  endfunction

  function automatic logic vs_at(input logic [9:0] py);
    return ((32'(py) >= VS_BEG) && (32'(py) < VS_END)) ? SYNC_POL : ~SYNC_POL;
  endfunction

  assign busy   = (state != IDLE);
  assign dot_en = busy && (div_cnt == cur_div - 4'd1);

  // Next counter position, frame-wrap detect and config handshake decode
  always_comb begin
    x_last      = (x == 10'(H_TOTAL - 1));
    y_last      = (y == 10'(V_TOTAL - 1));
    frame_end   = dot_en && x_last && y_last;
    nx          = x;
    ny          = y;
    if (dot_en) begin
      if (x_last) begin
        nx = '0;
        ny = y_last ? '0 : y + 10'd1;
      end else begin
        nx = x + 10'd1;
      end
    end
    cfg_clamped = (cfg_div < 4'd2) ? 4'd2 : cfg_div;
    xfer        = cfg_valid && cfg_ready;
    // a divider is pending exactly while cfg_ready is low
    apply       = !cfg_ready && ((state == IDLE) || frame_end);
  end

  // Sequencer FSM, divider, counters, registered video outputs and config
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_div     <= 4'(DIV);
      pend_div    <= '0;
      cfg_ready   <= 1'b1;
      div_cnt     <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (run) begin
            state       <= RUN;
            frame_start <= 1'b1;
            de          <= de_at('0, '0);
            hsync       <= hs_at('0);
            vsync       <= vs_at('0);
          end
        end
        RUN, DRAIN: begin
          div_cnt <= dot_en ? '0 : div_cnt + 4'd1;
          if (frame_end && (state == DRAIN) && !run) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            de    <= 1'b0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
          end else begin
            state       <= run ? RUN : DRAIN;
            x           <= nx;
            y           <= ny;
            de          <= de_at(nx, ny);
            hsync       <= hs_at(nx);
            vsync       <= vs_at(ny);
            frame_start <= frame_end;
          end
        end
        default: state <= IDLE;
      endcase

      // Transfer and apply are mutually exclusive: a transfer needs
      // cfg_ready high, an apply needs it low.
      if (apply) begin
        cur_div   <= pend_div;
        cfg_ready <= 1'b1;
      end else if (xfer) begin
        pend_div  <= cfg_clamped;
        cfg_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl using a reduced raster
// (16 x 8 total, 8 x 4 visible) so whole frames stay short.
module tb_vga_timing_ctrl;

  localparam int HT = 16;
  localparam int VT = 8;

  logic       clk200 = 1'b0;
  logic       rst_n;
  logic       run;
  logic       cfg_valid;
  logic [3:0] cfg_div;
  logic       cfg_ready;
  logic       dot_en;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic       busy;

  int total = 0;
  int bad   = 0;

  vga_timing_ctrl #(
    .DIV(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut (
    .clk200(clk200), .rst_n(rst_n), .run(run), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .dot_en(dot_en),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk200 = ~clk200;

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_div = 4'd0;
    repeat (3) @(negedge clk200);
    total++; if (dot_en !== 1'b0)      begin bad++; $display("FAIL rst_dot_en got=%b exp=0", dot_en); end
    total++; if (hsync !== 1'b1)       begin bad++; $display("FAIL rst_hsync got=%b exp=1", hsync); end
    total++; if (vsync !== 1'b1)       begin bad++; $display("FAIL rst_vsync got=%b exp=1", vsync); end
    total++; if (de !== 1'b0)          begin bad++; $display("FAIL rst_de got=%b exp=0", de); end
    total++; if (x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL rst_xy got=%0d,%0d exp=0,0", x, y); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (cfg_ready !== 1'b1)   begin bad++; $display("FAIL rst_cfg_ready got=%b exp=1", cfg_ready); end
    rst_n = 1'b1;
    @(negedge clk200);
  endtask

  // After entering RUN: first dot in cycle 8, next in cycle 16, one frame_start
  task automatic test_startup(input int exp_first, input int exp_second, input string tag);
    int first = 0, second = 0, fs_extra = 0;
    run = 1'b1;
    @(negedge clk200);
    total++; if (busy !== 1'b1 || frame_start !== 1'b1 || de !== 1'b1 || x !== 10'd0)
      begin bad++; $display("FAIL %s_entry busy=%b fs=%b de=%b x=%0d exp=1,1,1,0", tag, busy, frame_start, de, x); end
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk200);
      if (k > 1 && frame_start) fs_extra++;
      if (dot_en) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
    end
    total++; if (first != exp_first)   begin bad++; $display("FAIL %s_first_dot got=%0d exp=%0d", tag, first, exp_first); end
    total++; if (second != exp_second) begin bad++; $display("FAIL %s_second_dot got=%0d exp=%0d", tag, second, exp_second); end
    total++; if (fs_extra != 0)        begin bad++; $display("FAIL %s_fs_once extra=%0d exp=0", tag, fs_extra); end
  endtask

  task automatic test_full_frame;
    int dots = 0, des = 0, sig_err = 0, n = 0;
    logic ehs, evs, ede;
    while (!frame_start && n < 2000) begin @(negedge clk200); n++; end
    total++; if (!frame_start) begin bad++; $display("FAIL frame_wait timeout got=0 exp=1"); end
    n = 0;
    do begin
      ehs = !(x >= 10 && x < 13);
      evs = !(y >= 5 && y < 7);
      ede = (x < 8) && (y < 4);
      if (hsync !== ehs || vsync !== evs || de !== ede || x >= HT || y >= VT) begin
        if (sig_err < 4) $display("FAIL frame_sig x=%0d y=%0d hs=%b vs=%b de=%b exp=%b,%b,%b", x, y, hsync, vsync, de, ehs, evs, ede);
        sig_err++;
      end
      if (dot_en) begin dots++; if (de) des++; end
      @(negedge clk200); n++;
    end while (!frame_start && n < 3000);
    total++; if (dots != HT * VT) begin bad++; $display("FAIL frame_dots got=%0d exp=%0d", dots, HT * VT); end
    total++; if (des != 32)       begin bad++; $display("FAIL frame_de got=%0d exp=32", des); end
    total++; if (sig_err != 0)    begin bad++; $display("FAIL frame_sig_errors got=%0d exp=0", sig_err); end
  endtask

  task automatic test_drain;
    int n = 0, lx = -1, ly = -1, fs = 0, dots = 0;
    while (y != 10'd2 && n < 2000) begin @(negedge clk200); n++; end
    run = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      if (dot_en) begin lx = int'(x); ly = int'(y); end
      if (frame_start) fs++;
      @(negedge clk200); n++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0", busy); end
    total++; if (lx != HT - 1 || ly != VT - 1) begin bad++; $display("FAIL drain_last got=%0d,%0d exp=%0d,%0d", lx, ly, HT - 1, VT - 1); end
    total++; if (fs != 0 || frame_start !== 1'b0) begin bad++; $display("FAIL drain_fs got=%0d exp=0", fs); end
    total++; if (x !== 10'd0 || y !== 10'd0 || de !== 1'b0 || hsync !== 1'b1)
      begin bad++; $display("FAIL drain_idle x=%0d y=%0d de=%b hs=%b exp=0,0,0,1", x, y, de, hsync); end
    for (int k = 0; k < 40; k++) begin @(negedge clk200); if (dot_en) dots++; end
    total++; if (dots != 0) begin bad++; $display("FAIL idle_dots got=%0d exp=0", dots); end
  endtask

  task automatic test_drain_resume;
    int n = 0, last = -1, gap_err = 0, fs = 0, idle = 0;
    run = 1'b1;
    @(negedge clk200);
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL resume_start_fs got=%b exp=1", frame_start); end
    while (y != 10'd1 && n < 2000) begin @(negedge clk200); n++; end
    for (int k = 0; k < 100; k++) begin
      if (k == 1) run = 1'b0;
      if (k == 4) run = 1'b1;
      if (dot_en) begin
        if (last >= 0 && k - last != 8) gap_err++;
        last = k;
      end
      if (frame_start) fs++;
      if (!busy) idle++;
      @(negedge clk200);
    end
    total++; if (gap_err != 0 || idle != 0) begin bad++; $display("FAIL resume_gap gaps=%0d idle=%0d exp=0,0", gap_err, idle); end
    total++; if (fs != 0) begin bad++; $display("FAIL resume_fs got=%0d exp=0", fs); end
  endtask

  // Mid-frame divider change plus a second offer refused while pending
  task automatic test_cfg_midframe;
    int n = 0, cyc = 0, last = -1, gap8_err = 0, gap4_err = 0, dots4 = 0, ready_hi = 0;
    while (!(y == 10'd2 && cfg_ready) && n < 2000) begin @(negedge clk200); n++; end
    cfg_valid = 1'b1; cfg_div = 4'd4;
    @(negedge clk200);
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_ready_drop got=%b exp=0", cfg_ready); end
    cfg_div = 4'd6;
    for (int k = 0; k < 20; k++) begin
      if (cfg_ready) ready_hi++;
      if (dot_en) begin
        if (last >= 0 && cyc - last != 8) gap8_err++;
        last = cyc;
      end
      @(negedge clk200); cyc++;
    end
    cfg_valid = 1'b0;
    total++; if (ready_hi != 0) begin bad++; $display("FAIL cfg_pending_ready got=%0d exp=0", ready_hi); end
    n = 0;
    while (!frame_start && n < 2000) begin
      if (dot_en) begin
        if (last >= 0 && cyc - last != 8) gap8_err++;
        last = cyc;
      end
      @(negedge clk200); cyc++; n++;
    end
    total++; if (gap8_err != 0) begin bad++; $display("FAIL cfg_old_spacing errs=%0d exp=0", gap8_err); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_ready_rise got=%b exp=1", cfg_ready); end
    n = 0;
    while (dots4 < 10 && n < 200) begin
      if (dot_en) begin
        if (cyc - last != 4) gap4_err++;
        last = cyc; dots4++;
      end
      @(negedge clk200); cyc++; n++;
    end
    total++; if (gap4_err != 0 || dots4 != 10) begin bad++; $display("FAIL cfg_new_spacing errs=%0d dots=%0d exp=0,10", gap4_err, dots4); end
    n = 0;
    while (!frame_start && n < 1000) begin @(negedge clk200); n++; end
    last = -1; gap4_err = 0;
    for (int k = 0; k < 30; k++) begin
      if (dot_en) begin
        if (last >= 0 && k - last != 4) gap4_err++;
        last = k;
      end
      @(negedge clk200);
    end
    total++; if (gap4_err != 0) begin bad++; $display("FAIL cfg_refused_offer errs=%0d exp=0", gap4_err); end
  endtask

  task automatic test_cfg_idle;
    int n = 0;
    run = 1'b0;
    while (busy && n < 1500) begin @(negedge clk200); n++; end
    total++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_cfg_pre busy=%b rdy=%b exp=0,1", busy, cfg_ready); end
    cfg_valid = 1'b1; cfg_div = 4'd1;
    @(negedge clk200);
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL idle_cfg_drop got=%b exp=0", cfg_ready); end
    @(negedge clk200);
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_cfg_apply got=%b exp=1", cfg_ready); end
    test_startup(2, 4, "div2");
  endtask

  task automatic test_reset_mid;
    int n = 0;
    while (!(x == 10'd5 && y == 10'd2) && n < 2000) begin @(negedge clk200); n++; end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_cfg_ready got=%b exp=1", cfg_ready); end
    cfg_valid = 1'b1; cfg_div = 4'd5;
    @(negedge clk200);
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (x !== 10'd0 || y !== 10'd0 || busy !== 1'b0 || dot_en !== 1'b0)
      begin bad++; $display("FAIL mid_rst_async x=%0d y=%0d busy=%b dot=%b exp=0,0,0,0", x, y, busy, dot_en); end
    total++; if (cfg_ready !== 1'b1 || de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1)
      begin bad++; $display("FAIL mid_rst_outs rdy=%b de=%b hs=%b vs=%b exp=1,0,1,1", cfg_ready, de, hsync, vsync); end
    @(negedge clk200);
    rst_n = 1'b1;
    test_startup(8, 16, "restart");
  endtask

  initial begin
    test_reset();
    test_startup(8, 16, "div8");
    test_full_frame();
    test_drain();
    test_drain_resume();
    test_cfg_midframe();
    test_cfg_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
